quadrature_encoder_emulator: RTL



---
 rtl/quadrature_encoder_emulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/quadrature_encoder_emulator.sv
// Turns signed step commands into a registered {B,A} Gray-code stream at one edge per P clocks; first edge P cycles after accept.
// Commands are taken only while idle (cmd_ready_o low during a move); abort_i ends a move without done_o.
module quadrature_encoder_emulator #(
   parameter int STEP_WIDTH   = 16,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [STEP_WIDTH-1:0]   cmd_steps_i,
   input  logic [PERIOD_WIDTH-1:0] cmd_period_i,
   input  logic                    abort_i,
   output logic [1:0]              enc_o,
   output logic [STEP_WIDTH-1:0]   position_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [STEP_WIDTH-1:0]   STEP_ONE = STEP_WIDTH'(1);
   localparam logic [STEP_WIDTH-1:0]   STEP_ZERO = '0;
   localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] PER_ZERO = '0;

   logic [0:0]              state_q, state_d;
   logic                    dir_up_q, dir_up_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
   logic [STEP_WIDTH-1:0]   remaining_q, remaining_d;
   logic [1:0]              enc_q, enc_d;
   logic [STEP_WIDTH-1:0]   position_q, position_d;
   logic                    done_q, done_d;

   logic [STEP_WIDTH-1:0]   cmd_mag;
   logic [PERIOD_WIDTH-1:0] cmd_per;

   // One Gray step forward or backward along 00-01-11-10.
   function automatic logic [1:0] enc_next(input logic [1:0] e, input logic up);
      logic [1:0] n;
      case (e)
         2'b00:   n = up ? 2'b01 : 2'b10;
         2'b01:   n = up ? 2'b11 : 2'b00;
         2'b11:   n = up ? 2'b10 : 2'b01;
         default: n = up ? 2'b00 : 2'b11;
      endcase
      return n;
   endfunction

   // The most negative count negates to itself, which read unsigned is the right magnitude.
   assign cmd_mag = cmd_steps_i[STEP_WIDTH-1] ? (~cmd_steps_i + STEP_ONE) : cmd_steps_i;
   assign cmd_per = (cmd_period_i == PER_ZERO) ? PER_ONE : cmd_period_i;

   always_comb begin
      state_d     = state_q;
      dir_up_d    = dir_up_q;
      period_d    = period_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      enc_d       = enc_q;
      position_d  = position_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               dir_up_d    = ~cmd_steps_i[STEP_WIDTH-1];
               period_d    = cmd_per;
               timer_d     = cmd_per;
               remaining_d = cmd_mag;
               if (cmd_mag == STEP_ZERO) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (timer_q <= PER_ONE) begin
               enc_d       = enc_next(enc_q, dir_up_q);
               position_d  = dir_up_q ? (position_q + STEP_ONE) : (position_q - STEP_ONE);
               remaining_d = remaining_q - STEP_ONE;
               timer_d     = period_q;
               if (remaining_q == STEP_ONE) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q - PER_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         dir_up_q    <= 1'b1;
         period_q    <= PER_ONE;
         timer_q     <= PER_ZERO;
         remaining_q <= STEP_ZERO;
         enc_q       <= 2'b00;
         position_q  <= STEP_ZERO;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_up_q    <= dir_up_d;
         period_q    <= period_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         enc_q       <= enc_d;
         position_q  <= position_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q == S_RUN);
   assign done_o      = done_q;
   assign enc_o       = enc_q;
   assign position_o  = position_q;

endmodule
